mem_port_arbiter: RTL and testbench

Shares the single simulated memory port between instruction fetch (IF) and load/store (LS) requesters. Sits between the fetch/LSU stages and the DPI-backed memory adapter. Each side sees a valid/ready request channel and a pulsed response. Only one transaction is outstanding at a time. LS has fixed priority, with a starvation guard for IF.

---
 rtl/mem_port_arbiter.sv | 250 +++++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (IF) and load/store (LS), one transaction in flight.
// Optional REQ/WAIT watchdog with sticky err_timeout output is built when MEM_ARB_TIMEOUT_EN is defined.
module mem_port_arbiter #(
  parameter int XLEN       = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req_valid,
  output logic            if_req_ready,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_resp_valid,
  output logic [XLEN-1:0] if_resp_data,
  input  logic            ls_req_valid,
  output logic            ls_req_ready,
  input  logic [XLEN-1:0] ls_addr,
  input  logic            ls_we,
  input  logic [XLEN-1:0] ls_wdata,
  input  logic [7:0]      ls_wmask,
  output logic            ls_resp_valid,
  output logic [XLEN-1:0] ls_resp_data,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_wdata,
  output logic [7:0]      mem_wmask,
  input  logic            mem_resp_valid,
`ifdef MEM_ARB_TIMEOUT_EN
  output logic            err_timeout,
`endif
  input  logic [XLEN-1:0] mem_resp_data
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  localparam int            SW         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [SW-1:0] STARVE_ONE = SW'(1);

  logic [1:0]      state_q, state_d;
  logic            owner_q, owner_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic            mem_we_q, mem_we_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic [7:0]      mem_wmask_q, mem_wmask_d;
  logic [XLEN-1:0] if_rdata_q, if_rdata_d;
  logic [XLEN-1:0] ls_rdata_q, ls_rdata_d;

  logic if_grant_s;
  logic ls_grant_s;
  logic timeout_s;
  logic timeout_fire_s;

`ifdef MEM_ARB_TIMEOUT_EN
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        err_timeout_q, err_timeout_d;

  // Counter starts at 0 on the first REQ/WAIT cycle, so FFFE marks the 65535th cycle there.
  assign timeout_s = (wait_cnt_q == 16'hFFFE);
`else
  assign timeout_s = 1'b0;
`endif

  assign timeout_fire_s = timeout_s &&
                          (((state_q == S_REQ)  && !mem_req_ready) ||
                           ((state_q == S_WAIT) && !mem_resp_valid));

  // Arbitration: LS has priority unless IF has already lost STARVE_MAX contested rounds
  always_comb begin
    if_grant_s = 1'b0;
    ls_grant_s = 1'b0;
    if (state_q == S_IDLE) begin
      if (if_req_valid && ls_req_valid) begin
        if (starve_q == STARVE_LIM) begin
          if_grant_s = 1'b1;
        end else begin
          ls_grant_s = 1'b1;
        end
      end else begin
        if_grant_s = if_req_valid;
        ls_grant_s = ls_req_valid;
      end
    end else begin
      if_grant_s = 1'b0;
      ls_grant_s = 1'b0;
    end
  end

  // Starvation counter: saturating count of consecutive contested IF losses
  always_comb begin
    starve_d = starve_q;
    if (if_grant_s) begin
      starve_d = {SW{1'b0}};
    end else if (ls_grant_s && if_req_valid) begin
      if (starve_q == STARVE_LIM) begin
        starve_d = starve_q;
      end else begin
        starve_d = starve_q + STARVE_ONE;
      end
    end else begin
      starve_d = starve_q;
    end
  end

  // Transaction FSM and capture of the request and response registers
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (ls_grant_s) begin
          state_d     = S_REQ;
          owner_d     = OWN_LS;
          mem_addr_d  = ls_addr;
          mem_we_d    = ls_we;
          mem_wdata_d = ls_wdata;
          mem_wmask_d = ls_wmask;
        end else if (if_grant_s) begin
          state_d     = S_REQ;
          owner_d     = OWN_IF;
          mem_addr_d  = if_addr;
          mem_we_d    = 1'b0;
          mem_wdata_d = {XLEN{1'b0}};
          mem_wmask_d = 8'h00;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          state_d = S_WAIT;
        end else if (timeout_fire_s) begin
          state_d = S_RESP;
          if (owner_q == OWN_LS) begin
            ls_rdata_d = {XLEN{1'b0}};
          end else begin
            if_rdata_d = {XLEN{1'b0}};
          end
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        if (mem_resp_valid) begin
          state_d = S_RESP;
          if (owner_q == OWN_LS) begin
            ls_rdata_d = mem_resp_data;
          end else begin
            if_rdata_d = mem_resp_data;
          end
        end else if (timeout_fire_s) begin
          state_d = S_RESP;
          if (owner_q == OWN_LS) begin
            ls_rdata_d = {XLEN{1'b0}};
          end else begin
            if_rdata_d = {XLEN{1'b0}};
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef MEM_ARB_TIMEOUT_EN
  // Watchdog: held at zero in IDLE, restarted on REQ->WAIT, sticky error flag
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if ((state_q == S_IDLE) || ((state_q == S_REQ) && mem_req_ready)) begin
      wait_cnt_d = 16'h0000;
    end else if ((state_q == S_REQ) || (state_q == S_WAIT)) begin
      wait_cnt_d = wait_cnt_q + 16'h0001;
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
    err_timeout_d = err_timeout_q | timeout_fire_s;
  end

  // Watchdog state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q    <= 16'h0000;
      err_timeout_q <= 1'b0;
    end else begin
      wait_cnt_q    <= wait_cnt_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign err_timeout = err_timeout_q;
`endif

  // Arbiter state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_IF;
      starve_q    <= {SW{1'b0}};
      mem_addr_q  <= {XLEN{1'b0}};
      mem_we_q    <= 1'b0;
      mem_wdata_q <= {XLEN{1'b0}};
      mem_wmask_q <= 8'h00;
      if_rdata_q  <= {XLEN{1'b0}};
      ls_rdata_q  <= {XLEN{1'b0}};
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      starve_q    <= starve_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
    end
  end

  assign if_req_ready  = if_grant_s;
  assign ls_req_ready  = ls_grant_s;
  assign mem_req_valid = (state_q == S_REQ);
  assign mem_addr      = mem_addr_q;
  assign mem_we        = mem_we_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_wmask     = mem_wmask_q;
  assign if_resp_valid = (state_q == S_RESP) && (owner_q == OWN_IF);
  assign ls_resp_valid = (state_q == S_RESP) && (owner_q == OWN_LS);
  assign if_resp_data  = if_rdata_q;
  assign ls_resp_data  = ls_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed stimulus pushes expected memory requests and responses,
// a monitor process compares them as the DUT presents them; a small responder plays the memory side.
module tb_mem_port_arbiter;

  typedef struct {
    logic [63:0] addr;
    logic        we;
    logic [63:0] wdata;
    logic [7:0]  wmask;
  } req_t;

  typedef struct {
    logic        is_ls;
    logic [63:0] data;
  } rsp_t;

  typedef struct {
    string       name;
    logic [63:0] act;
    logic [63:0] exp;
  } chk_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req_valid = 1'b0;
  logic        if_req_ready;
  logic [63:0] if_addr = 64'd0;
  logic        if_resp_valid;
  logic [63:0] if_resp_data;
  logic        ls_req_valid = 1'b0;
  logic        ls_req_ready;
  logic [63:0] ls_addr = 64'd0;
  logic        ls_we = 1'b0;
  logic [63:0] ls_wdata = 64'd0;
  logic [7:0]  ls_wmask = 8'h00;
  logic        ls_resp_valid;
  logic [63:0] ls_resp_data;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_addr;
  logic        mem_we;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_data;
`ifdef MEM_ARB_TIMEOUT_EN
  logic        err_timeout;
`endif

  bit          cfg_auto = 1'b1;
  bit          cfg_never = 1'b0;
  int          cfg_stall = 0;
  logic [63:0] cfg_rdata = 64'd0;
  int          inject_req_n = 0;
  int          inject_done_n = 0;

  req_t mq[$];
  rsp_t rq[$];
  chk_t dq[$];
  int   checks = 0;
  int   failures = 0;

  mem_port_arbiter #(.XLEN(64), .STARVE_MAX(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .if_req_valid  (if_req_valid),
    .if_req_ready  (if_req_ready),
    .if_addr       (if_addr),
    .if_resp_valid (if_resp_valid),
    .if_resp_data  (if_resp_data),
    .ls_req_valid  (ls_req_valid),
    .ls_req_ready  (ls_req_ready),
    .ls_addr       (ls_addr),
    .ls_we         (ls_we),
    .ls_wdata      (ls_wdata),
    .ls_wmask      (ls_wmask),
    .ls_resp_valid (ls_resp_valid),
    .ls_resp_data  (ls_resp_data),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_we        (mem_we),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_resp_valid(mem_resp_valid),
`ifdef MEM_ARB_TIMEOUT_EN
    .err_timeout   (err_timeout),
`endif
    .mem_resp_data (mem_resp_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_t c;
    c.name = name;
    c.act  = act;
    c.exp  = exp;
    dq.push_back(c);
  endtask

  // Memory side: optional stall before ready, response one cycle after acceptance.
  initial begin : responder
    int rs;
    int left;
    rs = 0;
    left = 0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = 64'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rs = 0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
      end else begin
        mem_resp_valid = 1'b0;
        case (rs)
          0: begin
            if (inject_req_n != inject_done_n) begin
              mem_resp_valid = 1'b1;
              mem_resp_data  = 64'hBADBADBADBADBAD0;
              inject_done_n  = inject_done_n + 1;
            end else if (mem_req_valid) begin
              if (cfg_stall == 0 && !cfg_never) begin
                mem_req_ready = 1'b1;
                rs = 1;
              end else begin
                left = cfg_stall;
                rs = 3;
              end
            end
          end
          1: begin
            mem_req_ready = 1'b0;
            if (cfg_auto) begin
              mem_resp_valid = 1'b1;
              mem_resp_data  = cfg_rdata;
            end
            rs = 0;
          end
          3: begin
            if (!mem_req_valid) begin
              rs = 0;
            end else if (!cfg_never) begin
              left = left - 1;
              if (left <= 0) begin
                mem_req_ready = 1'b1;
                rs = 1;
              end
            end
          end
          default: rs = 0;
        endcase
      end
    end
  end

  // Monitor: the only process that compares and counts.
  initial begin : monitor
    chk_t c;
    req_t cur;
    rsp_t er;
    logic prev_mrv;
    logic [63:0] got;
    prev_mrv = 1'b0;
    cur = '{addr: 64'd0, we: 1'b0, wdata: 64'd0, wmask: 8'h00};
    forever begin
      @(negedge clk);
      while (dq.size() > 0) begin
        c = dq.pop_front();
        checks++;
        if (c.act !== c.exp) begin
          failures++;
          $display("FAIL %s: got 0x%0h expected 0x%0h", c.name, c.act, c.exp);
        end
      end
      if (rst_n) begin
        if (if_resp_valid || ls_resp_valid) begin
          checks++;
          if (if_resp_valid && ls_resp_valid) begin
            failures++;
            $display("FAIL resp_both: if_resp_valid=%0b ls_resp_valid=%0b expected one", if_resp_valid, ls_resp_valid);
          end else if (rq.size() == 0) begin
            failures++;
            $display("FAIL resp_unexpected: if=%0b ls=%0b expected no response", if_resp_valid, ls_resp_valid);
          end else begin
            er = rq.pop_front();
            got = ls_resp_valid ? ls_resp_data : if_resp_data;
            if (ls_resp_valid !== er.is_ls || got !== er.data) begin
              failures++;
              $display("FAIL resp: got ls=%0b data=0x%0h expected ls=%0b data=0x%0h", ls_resp_valid, got, er.is_ls, er.data);
            end
          end
        end
        if (mem_req_valid && !prev_mrv) begin
          checks++;
          if (mq.size() == 0) begin
            failures++;
            $display("FAIL mem_req_unexpected: addr=0x%0h expected no request", mem_addr);
          end else begin
            cur = mq.pop_front();
            if (mem_addr !== cur.addr || mem_we !== cur.we || mem_wmask !== cur.wmask ||
                (cur.we && mem_wdata !== cur.wdata)) begin
              failures++;
              $display("FAIL mem_req: got a=0x%0h we=%0b d=0x%0h m=0x%0h expected a=0x%0h we=%0b d=0x%0h m=0x%0h",
                       mem_addr, mem_we, mem_wdata, mem_wmask, cur.addr, cur.we, cur.wdata, cur.wmask);
            end
          end
        end else if (mem_req_valid) begin
          checks++;
          if (mem_addr !== cur.addr || mem_we !== cur.we || mem_wmask !== cur.wmask ||
              (cur.we && mem_wdata !== cur.wdata)) begin
            failures++;
            $display("FAIL mem_stable: got a=0x%0h we=%0b d=0x%0h m=0x%0h expected a=0x%0h we=%0b d=0x%0h m=0x%0h",
                     mem_addr, mem_we, mem_wdata, mem_wmask, cur.addr, cur.we, cur.wdata, cur.wmask);
          end
        end
      end
      prev_mrv = rst_n ? mem_req_valid : 1'b0;
    end
  end

  // Wait for a grant, check the winner, queue expected request/response, complete the handshake.
  task automatic grant(input string tag, input logic exp_ls, input logic [63:0] rdata,
                       input bit push_rsp, output int waits);
    req_t r;
    rsp_t p;
    int n;
    n = 0;
    #1;
    while (!(if_req_ready || ls_req_ready) && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({tag, "_grant_timeout"}, 64'(n >= 50), 64'd0);
    check({tag, "_ls_ready"}, 64'(ls_req_ready), 64'(exp_ls));
    check({tag, "_if_ready"}, 64'(if_req_ready), 64'(!exp_ls));
    if (exp_ls) begin
      r = '{addr: ls_addr, we: ls_we, wdata: ls_wdata, wmask: ls_wmask};
    end else begin
      r = '{addr: if_addr, we: 1'b0, wdata: 64'd0, wmask: 8'h00};
    end
    mq.push_back(r);
    if (push_rsp) begin
      p = '{is_ls: exp_ls, data: rdata};
      rq.push_back(p);
    end
    cfg_rdata = rdata;
    waits = n;
    @(posedge clk);
  endtask

  // Count negedges after the accepting edge until a response pulse; check against expected latency.
  task automatic wait_resp(input string tag, input int exp_lat, input int start_n,
                           input bit drop_if, input bit drop_ls);
    int n;
    bit seen;
    n = start_n;
    seen = 1'b0;
    while (!seen && n < exp_lat + 20) begin
      @(negedge clk);
      n++;
      if (drop_if) if_req_valid = 1'b0;
      if (drop_ls) ls_req_valid = 1'b0;
      #1;
      seen = if_resp_valid || ls_resp_valid;
    end
    check({tag, "_latency"}, 64'(n), 64'(exp_lat));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_if_ready"}, 64'(if_req_ready), 64'd0);
    check({tag, "_ls_ready"}, 64'(ls_req_ready), 64'd0);
    check({tag, "_mem_req_valid"}, 64'(mem_req_valid), 64'd0);
    check({tag, "_if_resp_valid"}, 64'(if_resp_valid), 64'd0);
    check({tag, "_ls_resp_valid"}, 64'(ls_resp_valid), 64'd0);
    check({tag, "_mem_addr"}, mem_addr, 64'd0);
    check({tag, "_mem_we"}, 64'(mem_we), 64'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 64'd0);
    check({tag, "_mem_wmask"}, 64'(mem_wmask), 64'd0);
    check({tag, "_if_resp_data"}, if_resp_data, 64'd0);
    check({tag, "_ls_resp_data"}, ls_resp_data, 64'd0);
  endtask

  initial begin : main
    int w;
    int k;
    logic exp_win [6];
    logic [63:0] data_tab [6];
    exp_win  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    data_tab = '{64'h1000, 64'h1001, 64'h1002, 64'h1003, 64'h1004, 64'h1005};

    // Reset values
    @(negedge clk);
    #1;
    check_reset_outputs("reset");
`ifdef MEM_ARB_TIMEOUT_EN
    check("reset_err_timeout", 64'(err_timeout), 64'd0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // IF only
    @(negedge clk);
    if_addr = 64'h0000_0000_8000_0000;
    if_req_valid = 1'b1;
    grant("if_only", 1'b0, 64'h0000001300100093, 1'b1, w);
    wait_resp("if_only", 3, 0, 1'b1, 1'b0);
    check("if_only_data", if_resp_data, 64'h0000001300100093);

    // Simultaneous IF and LS from reset
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ls_addr = 64'h0000_0000_8000_1000;
    ls_we = 1'b0;
    if_addr = 64'h0000_0000_8000_0004;
    ls_req_valid = 1'b1;
    if_req_valid = 1'b1;
    grant("both_ls", 1'b1, 64'h1122334455667788, 1'b1, w);
    wait_resp("both_ls", 3, 0, 1'b0, 1'b1);
    @(negedge clk);
    grant("both_if", 1'b0, 64'h00000000AABBCCDD, 1'b1, w);
    check("both_if_immediate", 64'(w), 64'd0);
    wait_resp("both_if", 3, 0, 1'b1, 1'b0);
    check("both_ls_data_held", ls_resp_data, 64'h1122334455667788);

    // Starvation guard: LS and IF both held valid
    @(negedge clk);
    ls_addr = 64'h0000_0000_8000_1008;
    if_addr = 64'h0000_0000_8000_0008;
    ls_req_valid = 1'b1;
    if_req_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      grant($sformatf("starve%0d", i), exp_win[i], data_tab[i], 1'b1, w);
      wait_resp($sformatf("starve%0d", i), 3, 0, 1'b0, 1'b0);
    end
    ls_req_valid = 1'b0;
    if_req_valid = 1'b0;

    // Store with memory stalling ready for 5 cycles; IF blips valid while busy
    @(negedge clk);
    ls_addr  = 64'h0000_0000_8000_2000;
    ls_we    = 1'b1;
    ls_wdata = 64'h0000_0000_DEAD_BEEF;
    ls_wmask = 8'h0F;
    ls_req_valid = 1'b1;
    cfg_stall = 5;
    grant("store", 1'b1, 64'h00000000CAFEF00D, 1'b1, w);
    @(negedge clk);
    ls_req_valid = 1'b0;
    if_req_valid = 1'b1;
    #1;
    check("busy_if_ready", 64'(if_req_ready), 64'd0);
    @(negedge clk);
    if_req_valid = 1'b0;
    wait_resp("store", 8, 2, 1'b0, 1'b0);
    cfg_stall = 0;
    ls_we = 1'b0;
    ls_wmask = 8'h00;

    // Reset during WAIT, stale response arriving after release
    @(negedge clk);
    cfg_auto = 1'b0;
    if_addr = 64'h0000_0000_8000_3000;
    if_req_valid = 1'b1;
    grant("rst_wait", 1'b0, 64'd0, 1'b0, w);
    @(negedge clk);
    if_req_valid = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    inject_req_n = inject_req_n + 1;
    repeat (4) @(negedge clk);
    #1;
    check("rst_mid_inject_done", 64'(inject_done_n), 64'(inject_req_n));
    check("rst_mid_idle_mem_req", 64'(mem_req_valid), 64'd0);
    check("rst_mid_if_data", if_resp_data, 64'd0);
    cfg_auto = 1'b1;
    @(negedge clk);
    if_req_valid = 1'b1;
    grant("after_rst", 1'b0, 64'h0000000000C0FFEE, 1'b1, w);
    check("after_rst_immediate", 64'(w), 64'd0);
    wait_resp("after_rst", 3, 0, 1'b1, 1'b0);

`ifdef MEM_ARB_TIMEOUT_EN
    // Memory never accepts: watchdog completes the transaction with zero data
    @(negedge clk);
    cfg_never = 1'b1;
    if_addr = 64'h0000_0000_8000_4000;
    if_req_valid = 1'b1;
    grant("timeout", 1'b0, 64'd0, 1'b1, w);
    wait_resp("timeout", 65536, 0, 1'b1, 1'b0);
    check("timeout_err", 64'(err_timeout), 64'd1);
    repeat (3) @(negedge clk);
    #1;
    check("timeout_err_sticky", 64'(err_timeout), 64'd1);
    cfg_never = 1'b0;
`endif

    repeat (5) @(negedge clk);
    check("rsp_queue_left", 64'(rq.size()), 64'd0);
    check("req_queue_left", 64'(mq.size()), 64'd0);
    k = 0;
    while (dq.size() > 0 && k < 10) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
